// File: rtl/counter_snapshot_fifo.sv
// counter_snapshot_fifo
//   Captures snapshots of an 8-bit counter value, either on an explicit
//   sample request or on each rising edge of the counter overflow. Each
//   snapshot is tagged with its source and a wrapping overflow-epoch number.
//   Snapshots are buffered in a FIFO that is drained over a valid/ready
//   handshake.
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   clr          in   synchronous clear: flush FIFO, zero epoch and drop_cnt
//   count_in     in   counter value to snapshot
//   overflow_in  in   counter overflow (pulse or level; rising edge counts)
//   sample_req   in   one-cycle snapshot request strobe
//   out_valid    out  head entry available
//   out_ready    in   consumer accepts head entry
//   out_count    out  snapshot count value (0 when out_valid=0)
//   out_epoch    out  epoch at capture, already including that capture's
//                     own overflow (0 when out_valid=0)
//   out_src      out  bit0 = sample request, bit1 = overflow (0 when idle)
//   fifo_level   out  entries held, 0..DEPTH
//   drop_cnt     out  saturating count of snapshots lost to a full FIFO

module counter_snapshot_fifo #(
   parameter int DEPTH   = 8,
   parameter int EPOCH_W = 8,
   parameter int DROP_W  = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clr,
   input  logic [7:0]                 count_in,
   input  logic                       overflow_in,
   input  logic                       sample_req,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [7:0]                 out_count,
   output logic [EPOCH_W-1:0]         out_epoch,
   output logic [1:0]                 out_src,
   output logic [$clog2(DEPTH):0]     fifo_level,
   output logic [DROP_W-1:0]          drop_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int EW = 8 + EPOCH_W + 2;

   // Input stage. These are deliberately untouched by clr so that an
   // overflow level held across a clear does not produce a second event.
   logic [7:0]         s1_count_q,  s1_count_d;
   logic               s1_ovf_q,    s1_ovf_d;
   logic               ovf_dly_q,   ovf_dly_d;
   logic               s1_sample_q, s1_sample_d;

   logic [EW-1:0]      mem_q [DEPTH];
   logic [EW-1:0]      mem_d [DEPTH];
   logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]      level_q,  level_d;
   logic [EPOCH_W-1:0] epoch_q,  epoch_d;
   logic [DROP_W-1:0]  drop_q,   drop_d;

   logic               ovf_rise;
   logic               push;
   logic               pop;
   logic               full;
   logic               wr_en;
   logic               drop;
   logic [EPOCH_W-1:0] epoch_next;
   logic [EW-1:0]      entry;
   logic [EW-1:0]      head;

   always_comb begin
      s1_count_d  = count_in;
      s1_ovf_d    = overflow_in;
      ovf_dly_d   = s1_ovf_q;
      s1_sample_d = sample_req;
   end

   always_comb begin
      ovf_rise   = s1_ovf_q & ~ovf_dly_q;
      push       = ovf_rise | s1_sample_q;
      pop        = (level_q != '0) & out_ready;
      full       = (level_q == LW'(DEPTH));
      // When full, a same-cycle pop frees the slot the push needs.
      wr_en      = push & (~full | pop);
      drop       = push & full & ~pop;
      epoch_next = epoch_q + EPOCH_W'(ovf_rise);
      entry      = {s1_count_q, epoch_next, ovf_rise, s1_sample_q};
   end

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      epoch_d  = epoch_q;
      drop_d   = drop_q;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
         epoch_d  = '0;
         drop_d   = '0;
      end else begin
         epoch_d = epoch_next;
         if (wr_en) begin
            mem_d[wr_ptr_q] = entry;
            wr_ptr_d        = wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         case ({wr_en, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
         endcase
         if (drop && (drop_q != '1)) begin
            drop_d = drop_q + DROP_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_count_q  <= '0;
         s1_ovf_q    <= 1'b0;
         ovf_dly_q   <= 1'b0;
         s1_sample_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         epoch_q     <= '0;
         drop_q      <= '0;
      end else begin
         s1_count_q  <= s1_count_d;
         s1_ovf_q    <= s1_ovf_d;
         ovf_dly_q   <= ovf_dly_d;
         s1_sample_q <= s1_sample_d;
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         epoch_q     <= epoch_d;
         drop_q      <= drop_d;
      end
   end

   always_comb begin
      head       = mem_q[rd_ptr_q];
      out_valid  = (level_q != '0);
      out_count  = out_valid ? head[EW-1 -: 8]       : '0;
      out_epoch  = out_valid ? head[EPOCH_W+1 -: EPOCH_W] : '0;
      out_src    = out_valid ? head[1:0]             : '0;
      fifo_level = level_q;
      drop_cnt   = drop_q;
   end

endmodule

// File: tb/tb_counter_snapshot_fifo.sv
// Scoreboard bench for counter_snapshot_fifo: stimulus pushes expected
// entries into a queue, a monitor pops and compares on every handshake.

module tb_counter_snapshot_fifo;

   logic       clk;
   logic       rst_n;
   logic       clr;
   logic [7:0] count_in;
   logic       overflow_in;
   logic       sample_req;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_count;
   logic [7:0] out_epoch;
   logic [1:0] out_src;
   logic [3:0] fifo_level;
   logic [7:0] drop_cnt;

   int n_cmp = 0;
   int n_bad = 0;
   logic [17:0] exp_q [$];

   counter_snapshot_fifo #(.DEPTH(8), .EPOCH_W(8), .DROP_W(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr         (clr),
      .count_in    (count_in),
      .overflow_in (overflow_in),
      .sample_req  (sample_req),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_count   (out_count),
      .out_epoch   (out_epoch),
      .out_src     (out_src),
      .fifo_level  (fifo_level),
      .drop_cnt    (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic sample(input logic [7:0] c);
      count_in   = c;
      sample_req = 1'b1;
      tick(1);
      sample_req = 1'b0;
   endtask

   // Monitor: a handshake seen at the negedge completes at the next posedge.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL pop_unexpected: got %0h/%0h/%0h expected no entry",
                     out_count, out_epoch, out_src);
         end else begin
            logic [17:0] e;
            e = exp_q.pop_front();
            check("pop_entry", {14'd0, out_count, out_epoch, out_src}, {14'd0, e});
         end
      end
   end

   initial begin
      rst_n       = 1'b0;
      clr         = 1'b0;
      count_in    = 8'h00;
      overflow_in = 1'b0;
      sample_req  = 1'b0;
      out_ready   = 1'b0;
      tick(3);
      rst_n = 1'b1;
      tick(2);
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_level", {28'd0, fifo_level}, 32'd0);
      check("rst_drop",  {24'd0, drop_cnt}, 32'd0);
      check("rst_out",   {14'd0, out_count, out_epoch, out_src}, 32'd0);

      // Basic sample, with latency: valid only after the second edge.
      out_ready = 1'b1;
      exp_q.push_back({8'h2A, 8'd0, 2'b01});
      sample(8'h2A);
      check("lat_edge_n", {31'd0, out_valid}, 32'd0);
      tick(1);
      check("lat_edge_n1", {31'd0, out_valid}, 32'd1);
      tick(2);
      check("basic_level", {28'd0, fifo_level}, 32'd0);

      // Overflow held three cycles -> a single entry.
      exp_q.push_back({8'hFF, 8'd1, 2'b10});
      count_in    = 8'hFF;
      overflow_in = 1'b1;
      tick(3);
      overflow_in = 1'b0;
      tick(4);
      check("ovf_level", {28'd0, fifo_level}, 32'd0);

      // Sample and overflow rise together -> one entry tagged 2'b11.
      out_ready   = 1'b0;
      exp_q.push_back({8'h55, 8'd2, 2'b11});
      count_in    = 8'h55;
      overflow_in = 1'b1;
      sample_req  = 1'b1;
      tick(1);
      sample_req  = 1'b0;
      overflow_in = 1'b0;
      tick(2);
      check("sim_level", {28'd0, fifo_level}, 32'd1);
      out_ready = 1'b1;
      tick(2);
      out_ready = 1'b0;
      check("sim_drained", {28'd0, fifo_level}, 32'd0);

      // Ten samples into an 8-deep FIFO with no consumer.
      for (int i = 0; i < 10; i++) begin
         if (i < 8) exp_q.push_back({8'h10 + 8'(i), 8'd2, 2'b01});
         count_in   = 8'h10 + 8'(i);
         sample_req = 1'b1;
         tick(1);
      end
      sample_req = 1'b0;
      tick(3);
      check("full_level", {28'd0, fifo_level}, 32'd8);
      check("full_drop",  {24'd0, drop_cnt}, 32'd2);
      check("hold_count", {24'd0, out_count}, 32'h10);

      // Push and pop together while full.
      exp_q.push_back({8'hA0, 8'd2, 2'b01});
      sample(8'hA0);
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
      tick(1);
      check("pp_level", {28'd0, fifo_level}, 32'd8);
      check("pp_drop",  {24'd0, drop_cnt}, 32'd2);

      // Drain in order.
      out_ready = 1'b1;
      tick(10);
      out_ready = 1'b0;
      check("drain_level", {28'd0, fifo_level}, 32'd0);

      // clr flushes held entries and zeroes epoch and drop count.
      sample(8'hC1);
      sample(8'hC2);
      tick(2);
      check("pre_clr_level", {28'd0, fifo_level}, 32'd2);
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      check("clr_level", {28'd0, fifo_level}, 32'd0);
      check("clr_valid", {31'd0, out_valid}, 32'd0);
      check("clr_drop",  {24'd0, drop_cnt}, 32'd0);
      out_ready = 1'b1;
      exp_q.push_back({8'h77, 8'd0, 2'b01});
      sample(8'h77);
      tick(4);
      out_ready = 1'b0;
      check("post_clr_level", {28'd0, fifo_level}, 32'd0);

      // Asynchronous reset mid-operation discards held entries at once.
      sample(8'h33);
      tick(2);
      check("pre_rst_level", {28'd0, fifo_level}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_level", {28'd0, fifo_level}, 32'd0);
      check("arst_valid", {31'd0, out_valid}, 32'd0);
      check("arst_out",   {14'd0, out_count, out_epoch, out_src}, 32'd0);
      exp_q.delete();
      tick(2);
      rst_n = 1'b1;
      tick(3);
      check("rel_level", {28'd0, fifo_level}, 32'd0);

      check("sb_empty", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
